ahb_vga_coords: RTL and testbench
=================================

# ahb_vga_coords

AHB-Lite slave peripheral that gives the Cortex-M0 inside `arm_soc` a software-visible set of rectangle coordinates and hands them to the `razzle` VGA renderer as `x1`, `x2`, `y1`, `y2` plus `DataValid`. The CPU writes shadow registers and requests a commit. Active outputs update only on the start of vertical sync, so the renderer never draws a torn frame. It is the stage directly upstream of `razzle`, inside `arm_soc`'s bus fabric.

## Interface
Parameters:
- `BASE_UNUSED_BITS`, default 27: upper `HADDR` bits ignored; decode uses `HADDR[4:2]`.
- `FRAME_CNT_W`, default 8: width of the frame counter.

Ports:
- `HCLK` input 1: system clock (50 MHz, same domain as the VGA timing).
- `HRESETn` input 1: reset, asynchronous active-low.
- `HSEL` input 1: slave select.
- `HADDR` input 32: byte address.
- `HTRANS` input 2: transfer type; `HTRANS[1]` = NONSEQ/SEQ.
- `HWRITE` input 1: write enable.
- `HSIZE` input 3: ignored; all accesses are treated as word accesses.
- `HWDATA` input 32: write data.
- `HREADY` input 1: bus ready.
- `HRDATA` output 32: read data.
- `HREADYOUT` output 1: tied to 1 (zero wait states).
- `HRESP` output 1: tied to 0 (OKAY).
- `VGA_VS` input 1: vertical sync from `razzle`, active low, same clock domain.
- `x1`, `x2` output 10: active horizontal coordinates.
- `y1`, `y2` output 10: active vertical coordinates.
- `DataValid` output 1: the active coordinates are meaningful.
- `CommitPending` output 1: a commit is waiting for vsync.

## Operation
Register map (word offsets):
- `0x00` X1, `0x04` X2, `0x08` Y1, `0x0C` Y2: shadow registers, read/write, bits [9:0]. Upper bits are ignored on write and read as 0.
- `0x10` CTRL (write-only, reads 0):
  - bit0 = commit request; sets pending.
  - bit1 = blank; clears `DataValid` in the next cycle.
  - bit1 has priority over a commit landing in the same cycle.
- `0x14` STATUS (read-only):
  - bit0 = pending.
  - bit1 = `DataValid`.
  - bits [15:8] = frame counter.
- `0x18`, `0x1C`: write-ignored, read 0.

Bus behaviour:
- Address phase is captured when `HSEL && HREADY && HTRANS[1]`. `HADDR[4:2]` and `HWRITE` are registered.
- Write data is applied at the end of the data phase, on the following `HCLK` edge.
- `HRDATA` is driven combinationally in the data phase from the registered address and the current register values.

Vsync and commit:
- Vsync edge = `VGA_VS` registered once; `vs_fall` = previous 1, current 0.
- On `vs_fall` with pending = 1:
  - Shadow values are copied to active outputs.
  - `DataValid` is set to 1 and pending is cleared.
- Every `vs_fall` increments the frame counter, which wraps from 255 to 0.

Boundary rules:
- Shadow write and commit in the same cycle: the commit copies the pre-write shadow value. The write lands in shadow only.
- CTRL commit write whose update edge coincides with `vs_fall`: no commit on that edge. Pending becomes 1 and the commit happens on the next frame.
- Commit request while already pending: pending stays 1 (idempotent).
- Blank while pending: `DataValid` is cleared and pending is preserved. The next vsync commits and sets `DataValid` again.

## Timing
- Reset values:
  - All shadow and active coordinates = 0.
  - `DataValid` = 0, `CommitPending` = 0, frame counter = 0.
  - `HRDATA` = 0, `HREADYOUT` = 1, `HRESP` = 0.
  - VS register = 1, registered address phase cleared.
- Write latency: the shadow register updates 1 cycle after the address phase.
- Commit latency: outputs change on the `HCLK` edge after the cycle in which `vs_fall` is true. That is 2 edges after `VGA_VS` falls.
- Reset asserted mid-frame or mid-transfer: all state returns to reset values immediately. A pending commit is lost.

## Configuration
- `COORD_CLAMP_EN` defined:
  - At commit, x values above 639 become 639 and y values above 479 become 479.
  - Then, if x1 > x2 the pair is swapped; the same applies to y.
  - Shadow registers keep the raw values.
- `COORD_CLAMP_EN` undefined: the raw 10-bit shadow values are copied unchanged.

## Structure
- Package `vga_coord_pkg` contains:
  - `coord_t` (`logic [9:0]`).
  - Register offset constants `REG_X1`…`REG_STATUS`.
  - `H_ACTIVE = 640` and `V_ACTIVE = 480`.
  - CTRL bit positions.
- Sub-module `coord_clamp`: combinational clamp-and-order of one (a, b) pair against a limit. It is instantiated twice, for x and y.
- `coord_clamp` is present only under `COORD_CLAMP_EN`.

## Test plan
- Reset: all outputs 0, `HREADYOUT` = 1, STATUS reads 0x0000.
- Write X1=10, X2=200, Y1=20, Y2=100, then CTRL=1:
  - STATUS bit0 = 1 and outputs stay 0.
  - After `VGA_VS` falls, outputs = 10/200/20/100 and `DataValid` = 1.
  - STATUS bit0 = 0 and frame counter = 1.
- Write X1=300 in the same cycle as a committing `vs_fall` (shadow X1 previously 10): active `x1` = 10 and readback of X1 = 300.
- CTRL=1 with its update edge coinciding with `vs_fall`:
  - No commit on that edge.
  - The commit occurs on the next `vs_fall`.
- With `COORD_CLAMP_EN`: X1=700, X2=5, Y1=500, Y2=0 committed gives `x1`=5, `x2`=639, `y1`=0, `y2`=479.
- Apply 256 `vs_fall` events: frame counter returns to 0. Then CTRL=2 gives `DataValid` = 0 on the next cycle, and pending is unchanged.

Source files
------------

// File: rtl/vga_coord_pkg.sv
// Shared types and register map for the AHB VGA coordinate peripheral.
package vga_coord_pkg;

    typedef logic [9:0] coord_t;

    // Word index decoded from HADDR[4:2]
    typedef enum logic [2:0] {
        REG_X1     = 3'd0,
        REG_X2     = 3'd1,
        REG_Y1     = 3'd2,
        REG_Y2     = 3'd3,
        REG_CTRL   = 3'd4,
        REG_STATUS = 3'd5,
        REG_RSVD6  = 3'd6,
        REG_RSVD7  = 3'd7
    } reg_idx_t;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    localparam coord_t X_MAX = coord_t'(H_ACTIVE - 1);
    localparam coord_t Y_MAX = coord_t'(V_ACTIVE - 1);

    localparam int unsigned CTRL_COMMIT_BIT = 0;
    localparam int unsigned CTRL_BLANK_BIT  = 1;

endpackage

// File: rtl/coord_clamp.sv
// Clamp a coordinate pair to LIMIT and order it so lo <= hi.
// Only built when COORD_CLAMP_EN is defined.
`ifdef COORD_CLAMP_EN
module coord_clamp
    import vga_coord_pkg::*;
#(
    parameter coord_t LIMIT = X_MAX
) (
    input  coord_t a,
    input  coord_t b,
    output coord_t lo,
    output coord_t hi
);

    coord_t ca;
    coord_t cb;

    always_comb begin
        ca = (a > LIMIT) ? LIMIT : a;
        cb = (b > LIMIT) ? LIMIT : b;
        if (ca > cb) begin
            lo = cb;
            hi = ca;
        end else begin
            lo = ca;
            hi = cb;
        end
    end

endmodule
`endif

// File: rtl/ahb_vga_coords.sv
// AHB-Lite slave holding shadow rectangle coordinates, committed to the VGA
// renderer on vsync falling edge. Optional clamp/order stage: COORD_CLAMP_EN.
module ahb_vga_coords
    import vga_coord_pkg::*;
#(
    parameter int unsigned BASE_UNUSED_BITS = 27,
    parameter int unsigned FRAME_CNT_W      = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    input  logic        VGA_VS,
    output logic [9:0]  x1,
    output logic [9:0]  x2,
    output logic [9:0]  y1,
    output logic [9:0]  y2,
    output logic        DataValid,
    output logic        CommitPending
);

    logic     ap_valid;
    logic     ap_write;
    reg_idx_t ap_addr;

    coord_t sh_x1, sh_x2, sh_y1, sh_y2;
    coord_t nx1, nx2, ny1, ny2;

    logic vs_q, vs_q2, vs_fall;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    logic wr_en, ctrl_wr, commit_req, blank_req, commit;
    logic [31:0] status_word;
    logic unused_bits;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    assign unused_bits = ^{HADDR[31:32-BASE_UNUSED_BITS], HADDR[1:0], HSIZE,
                           HTRANS[0], HWDATA[31:10]};

    assign vs_fall    = vs_q2 & ~vs_q;
    assign wr_en      = ap_valid & ap_write;
    assign ctrl_wr    = wr_en && (ap_addr == REG_CTRL);
    assign commit_req = ctrl_wr & HWDATA[CTRL_COMMIT_BIT];
    assign blank_req  = ctrl_wr & HWDATA[CTRL_BLANK_BIT];
    assign commit     = vs_fall & CommitPending;

`ifdef COORD_CLAMP_EN
    coord_clamp #(.LIMIT(X_MAX)) u_clamp_x (.a(sh_x1), .b(sh_x2), .lo(nx1), .hi(nx2));
    coord_clamp #(.LIMIT(Y_MAX)) u_clamp_y (.a(sh_y1), .b(sh_y2), .lo(ny1), .hi(ny2));
`else
    assign nx1 = sh_x1;
    assign nx2 = sh_x2;
    assign ny1 = sh_y1;
    assign ny2 = sh_y2;
`endif

    always_comb begin
        status_word = '0;
        status_word[0] = CommitPending;
        status_word[1] = DataValid;
        status_word[8 +: FRAME_CNT_W] = frame_cnt;
    end

    always_comb begin
        HRDATA = '0;
        if (ap_valid && !ap_write) begin
            case (ap_addr)
                REG_X1:     HRDATA = 32'(sh_x1);
                REG_X2:     HRDATA = 32'(sh_x2);
                REG_Y1:     HRDATA = 32'(sh_y1);
                REG_Y2:     HRDATA = 32'(sh_y2);
                REG_STATUS: HRDATA = status_word;
                default:    HRDATA = '0;
            endcase
        end
    end

    // Commit reads the shadow values before this edge's write; a CTRL commit
    // landing on a vs_fall edge only arms pending for the next frame.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_valid      <= 1'b0;
            ap_write      <= 1'b0;
            ap_addr       <= REG_X1;
            sh_x1         <= '0;
            sh_x2         <= '0;
            sh_y1         <= '0;
            sh_y2         <= '0;
            x1            <= '0;
            x2            <= '0;
            y1            <= '0;
            y2            <= '0;
            DataValid     <= 1'b0;
            CommitPending <= 1'b0;
            vs_q          <= 1'b1;
            vs_q2         <= 1'b1;
            frame_cnt     <= '0;
        end else begin
            ap_valid <= HSEL & HREADY & HTRANS[1];
            ap_write <= HWRITE;
            ap_addr  <= reg_idx_t'(HADDR[4:2]);
            vs_q     <= VGA_VS;
            vs_q2    <= vs_q;

            if (wr_en) begin
                case (ap_addr)
                    REG_X1:  sh_x1 <= HWDATA[9:0];
                    REG_X2:  sh_x2 <= HWDATA[9:0];
                    REG_Y1:  sh_y1 <= HWDATA[9:0];
                    REG_Y2:  sh_y2 <= HWDATA[9:0];
                    default: ;
                endcase
            end

            if (vs_fall)
                frame_cnt <= frame_cnt + 1'b1;

            if (commit) begin
                x1 <= nx1;
                x2 <= nx2;
                y1 <= ny1;
                y2 <= ny2;
            end

            if (commit_req)
                CommitPending <= 1'b1;
            else if (commit)
                CommitPending <= 1'b0;

            if (blank_req)
                DataValid <= 1'b0;
            else if (commit)
                DataValid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_vga_coords.sv
// Self-checking bench for ahb_vga_coords: table vectors, directed corner
// sequences and randomized bus/vsync traffic against a transaction-level model.
module tb_ahb_vga_coords;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        VGA_VS;
    logic [9:0]  x1, x2, y1, y2;
    logic        DataValid;
    logic        CommitPending;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Transaction-level model
    int unsigned m_sh[4];
    int unsigned m_act[4];
    bit          m_pend;
    bit          m_dv;
    int unsigned m_frame;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tbl[8];

    always #5 HCLK = ~HCLK;

    ahb_vga_coords #(.BASE_UNUSED_BITS(27), .FRAME_CNT_W(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .VGA_VS(VGA_VS), .x1(x1), .x2(x2), .y1(y1), .y2(y2),
        .DataValid(DataValid), .CommitPending(CommitPending)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int unsigned min_u(int unsigned a, int unsigned b);
        return (a < b) ? a : b;
    endfunction

    function automatic int unsigned max_u(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
        m_pend = 0;
        m_dv = 0;
        m_frame = 0;
    endtask

    task automatic model_vsync();
        int unsigned a, b, c, d;
        m_frame = (m_frame + 1) % 256;
        if (m_pend) begin
`ifdef COORD_CLAMP_EN
            a = min_u(m_sh[0], 639);
            b = min_u(m_sh[1], 639);
            c = min_u(m_sh[2], 479);
            d = min_u(m_sh[3], 479);
            m_act[0] = min_u(a, b);
            m_act[1] = max_u(a, b);
            m_act[2] = min_u(c, d);
            m_act[3] = max_u(c, d);
`else
            for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
`endif
            m_dv = 1;
            m_pend = 0;
        end
    endtask

    task automatic model_write(input int unsigned idx, input logic [31:0] data);
        if (idx < 4) m_sh[idx] = data % 1024;
        else if (idx == 4) begin
            if (data[0]) m_pend = 1;
            if (data[1]) m_dv = 0;
        end
    endtask

    function automatic logic [31:0] model_read(input int unsigned idx);
        if (idx < 4) return m_sh[idx];
        if (idx == 5) return m_frame * 256 + (m_dv ? 2 : 0) + (m_pend ? 1 : 0);
        return 0;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".x1"}, 32'(x1), m_act[0]);
        check({tag, ".x2"}, 32'(x2), m_act[1]);
        check({tag, ".y1"}, 32'(y1), m_act[2]);
        check({tag, ".y2"}, 32'(y2), m_act[3]);
        check({tag, ".DataValid"}, 32'(DataValid), 32'(m_dv));
        check({tag, ".CommitPending"}, 32'(CommitPending), 32'(m_pend));
    endtask

    // All bus tasks start and end at 1 time unit after a rising edge.
    task automatic bus_xfer(input logic [2:0] idx, input logic [31:0] data,
                            input logic wr, input logic [1:0] trans);
        logic [26:0] hi;
        logic [1:0]  lo;
        hi = 27'($urandom);
        lo = 2'($urandom);
        HSEL = 1'b1;
        HTRANS = trans;
        HWRITE = wr;
        HSIZE = 3'($urandom_range(0, 2));
        HADDR = {hi, idx, lo};
        @(posedge HCLK); #1;
        HSEL = 1'b0;
        HTRANS = 2'b00;
        HWDATA = data;
        @(posedge HCLK); #1;
    endtask

    task automatic bus_write(input logic [2:0] idx, input logic [31:0] data);
        bus_xfer(idx, data, 1'b1, 2'b10);
    endtask

    task automatic bus_read(input logic [2:0] idx, output logic [31:0] data);
        HSEL = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b0;
        HADDR = {27'($urandom), idx, 2'b00};
        @(posedge HCLK); #1;
        HSEL = 1'b0;
        HTRANS = 2'b00;
        data = HRDATA;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK); #1;
        end
    endtask

    task automatic vsync();
        VGA_VS = 1'b0;
        cycles(2);
        VGA_VS = 1'b1;
        cycles(2);
        model_vsync();
    endtask

    // Bus write whose update edge lines up with the vs_fall edge.
    task automatic write_at_vsync(input logic [2:0] idx, input logic [31:0] data);
        VGA_VS = 1'b0;
        bus_write(idx, data);
        VGA_VS = 1'b1;
        cycles(2);
        model_vsync();
        model_write(idx, data);
    endtask

    task automatic write_m(input logic [2:0] idx, input logic [31:0] data);
        bus_write(idx, data);
        model_write(idx, data);
    endtask

    initial begin
        logic [31:0] rd;
        int unsigned op, idx;
        logic [31:0] d;

        HRESETn = 1'b0;
        HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HWDATA = '0; HREADY = 1'b1; VGA_VS = 1'b1;
        model_reset();

        tbl[0] = '{3'd0, 32'hFFFF_FC05, 32'h0000_0005};
        tbl[1] = '{3'd1, 32'h0000_03FF, 32'h0000_03FF};
        tbl[2] = '{3'd2, 32'h1234_5678, 32'h0000_0278};
        tbl[3] = '{3'd3, 32'h0000_0000, 32'h0000_0000};
        tbl[4] = '{3'd4, 32'h0000_0000, 32'h0000_0000};
        tbl[5] = '{3'd6, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[6] = '{3'd7, 32'hA5A5_A5A5, 32'h0000_0000};
        tbl[7] = '{3'd3, 32'h0000_01E0, 32'h0000_01E0};

        cycles(2);
        check_outputs("reset");
        check("reset.HREADYOUT", 32'(HREADYOUT), 32'd1);
        check("reset.HRESP", 32'(HRESP), 32'd0);
        check("reset.HRDATA", HRDATA, 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        cycles(1);
        bus_read(3'd5, rd);
        check("reset.status", rd, 32'h0);

        // Basic commit flow and its two-edge latency from VGA_VS falling.
        write_m(3'd0, 10);
        write_m(3'd1, 200);
        write_m(3'd2, 20);
        write_m(3'd3, 100);
        write_m(3'd4, 1);
        bus_read(3'd5, rd);
        check("commit.status_pending", rd, 32'h1);
        check_outputs("commit.pre");
        VGA_VS = 1'b0;
        @(posedge HCLK); #1;
        check("commit.latency_x1", 32'(x1), 32'd0);
        @(posedge HCLK); #1;
        check("commit.x1", 32'(x1), 32'd10);
        check("commit.x2", 32'(x2), 32'd200);
        check("commit.y1", 32'(y1), 32'd20);
        check("commit.y2", 32'(y2), 32'd100);
        check("commit.dv", 32'(DataValid), 32'd1);
        VGA_VS = 1'b1;
        cycles(2);
        model_vsync();
        bus_read(3'd5, rd);
        check("commit.status", rd, 32'h0000_0102);

        // Shadow write coinciding with a committing vs_fall.
        write_m(3'd4, 1);
        write_at_vsync(3'd0, 300);
        check("wr_vs.x1_active", 32'(x1), 32'd10);
        bus_read(3'd0, rd);
        check("wr_vs.x1_shadow", rd, 32'd300);
        check_outputs("wr_vs");

        // CTRL commit coinciding with vs_fall arms the next frame only.
        write_m(3'd1, 250);
        write_at_vsync(3'd4, 1);
        check("ctrl_vs.x2_hold", 32'(x2), 32'd200);
        check("ctrl_vs.pending", 32'(CommitPending), 32'd1);
        vsync();
        check("ctrl_vs.x2_next", 32'(x2), 32'd250);
        check_outputs("ctrl_vs");

        // Idempotent commit, blank coinciding with a committing vs_fall.
        write_m(3'd4, 1);
        write_m(3'd4, 1);
        check("idem.pending", 32'(CommitPending), 32'd1);
        write_at_vsync(3'd4, 2);
        check("blank_vs.dv", 32'(DataValid), 32'd0);
        check_outputs("blank_vs");

        // Clamp / raw copy of out-of-range values.
        write_m(3'd0, 700);
        write_m(3'd1, 5);
        write_m(3'd2, 500);
        write_m(3'd3, 0);
        write_m(3'd4, 1);
        vsync();
`ifdef COORD_CLAMP_EN
        check("clamp.x1", 32'(x1), 32'd5);
        check("clamp.x2", 32'(x2), 32'd639);
        check("clamp.y1", 32'(y1), 32'd0);
        check("clamp.y2", 32'(y2), 32'd479);
`else
        check("raw.x1", 32'(x1), 32'd700);
        check("raw.x2", 32'(x2), 32'd5);
        check("raw.y1", 32'(y1), 32'd500);
        check("raw.y2", 32'(y2), 32'd0);
`endif
        bus_read(3'd0, rd);
        check("clamp.shadow_x1", rd, 32'd700);

        // Table vectors: masking, reserved and write-only registers.
        foreach (tbl[i]) begin
            write_m(tbl[i].idx, tbl[i].wdata);
            bus_read(tbl[i].idx, rd);
            check($sformatf("tbl[%0d]", i), rd, tbl[i].exp_rd);
        end
        check_outputs("tbl");

        // Reset during a transfer with a commit pending.
        write_m(3'd4, 1);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'd123;
        HRESETn = 1'b0;
        #1;
        model_reset();
        check_outputs("midreset");
        check("midreset.HRDATA", HRDATA, 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        cycles(1);
        bus_read(3'd0, rd);
        check("midreset.x1_shadow", rd, 32'd0);
        bus_read(3'd5, rd);
        check("midreset.status", rd, 32'd0);

        // Frame counter wrap, then blank with pending held.
        write_m(3'd0, 1);
        write_m(3'd4, 1);
        for (int i = 0; i < 255; i++) vsync();
        bus_read(3'd5, rd);
        check("wrap.frame255", rd, model_read(5));
        check("wrap.frame255_abs", rd, 32'h0000_FF02);
        vsync();
        bus_read(3'd5, rd);
        check("wrap.frame0", rd, 32'h0000_0002);
        write_m(3'd4, 1);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h10;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'd2;
        check("blank.dv_before", 32'(DataValid), 32'd1);
        @(posedge HCLK); #1;
        model_write(4, 2);
        check("blank.dv_after", 32'(DataValid), 32'd0);
        check("blank.pending", 32'(CommitPending), 32'd1);
        vsync();
        check_outputs("blank.recommit");

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: begin
                    idx = $urandom_range(0, 3);
                    d = $urandom;
                    write_m(3'(idx), d);
                end
                2: write_m(3'd4, 32'($urandom_range(0, 3)));
                3: vsync();
                4: begin
                    idx = $urandom_range(0, 7);
                    bus_read(3'(idx), rd);
                    check($sformatf("rnd.read[%0d]", idx), rd, model_read(idx));
                end
                default: begin
                    idx = $urandom_range(0, 4);
                    bus_xfer(3'(idx), 32'hFFFF_FFFF, 1'b1, 2'b00);
                end
            endcase
            check_outputs("rnd");
        end

        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), rd);
            check($sformatf("final.read[%0d]", i), rd, model_read(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
